// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial two's-complement adder/subtractor.
//
// One full-adder stage processes the latched operands one bit per cycle,
// LSB first. A WIDTH-bit operation takes WIDTH RUN cycles followed by a
// single DONE cycle carrying the done pulse.
//
// Ports:
//   clk     in   single clock, rising edge
//   rst     in   synchronous, active-high reset
//   start   in   operation request, accepted only in IDLE
//   sub     in   0 = a + b, 1 = a - b (b inverted, carry-in 1)
//   a, b    in   WIDTH-bit operands, captured with start
//   busy    out  high while bits are being processed (RUN)
//   done    out  one-cycle completion pulse (DONE)
//   result  out  WIDTH-bit sum/difference, held until the next completion
//   cout    out  final carry-out (for sub: 1 = no borrow)
//   ovf     out  signed overflow
//   zero    out  result == 0
//   neg     out  result MSB
//
// Optional build macro SERIAL_ADD_SUB_FLAGS_EN: when defined, the ovf/zero/neg
// flag registers are built; otherwise those ports are tied to 0.

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;

  logic               b_bit;
  logic               s_bit;
  logic               c_next;
  logic               last_bit;
  logic [WIDTH-1:0]   acc_next;

  // Full-adder stage on the current LSBs of the shifting operand registers
  assign b_bit    = b_q[0] ^ sub_q;
  assign s_bit    = fa_sum(a_q[0], b_bit, carry_q);
  assign c_next   = fa_carry(a_q[0], b_bit, carry_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0
  assign acc_next = {s_bit, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_next;
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = acc_next;
          cout_d   = c_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ADD_SUB_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Flags are captured together with result on the RUN->DONE transition.
  // carry_q still holds the carry into the MSB during the last RUN cycle.
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if ((state_q == RUN) && last_bit) begin
      ovf_d  = carry_q ^ c_next;
      zero_d = (acc_next == '0);
      neg_d  = acc_next[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
  assign neg  = 1'b0;
`endif

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed testbench for serial_add_sub (WIDTH = 8). Flag expectations follow
// whether SERIAL_ADD_SUB_FLAGS_EN is defined for the build.

module tb_serial_add_sub;

`ifdef SERIAL_ADD_SUB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       neg;

  int n_checks;
  int n_errors;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero),
    .neg    (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic fl(input logic v);
    return FLAGS_ON ? v : 1'b0;
  endfunction

  // Launch one operation and wait for done. lat counts rising edges from the
  // start-sampling edge (edge 1) to the edge after which done is high.
  task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                        output int lat);
    logic [7:0] held;
    held  = result;
    sub   = s;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    a     = ~av;
    b     = ~bv;
    sub   = ~s;
    check("busy_in_run", busy, 1);
    check("result_hold_in_run", result, held);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    a   = '0;
    b   = '0;
    sub = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] r, input logic c,
                               input logic o, input logic z, input logic n);
    check({tag, "_result"}, result, r);
    check({tag, "_cout"}, cout, c);
    check({tag, "_ovf"}, ovf, fl(o));
    check({tag, "_zero"}, zero, fl(z));
    check({tag, "_neg"}, neg, fl(n));
  endtask

  initial begin
    int lat;
    int pulses;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_outputs("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0x3C + 0x25
    run_op(1'b0, 8'h3C, 8'h25, lat);
    check("add1_latency", lat, 9);
    check("add1_done", done, 1);
    check("add1_busy", busy, 0);
    check_outputs("add1", 8'h61, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("add1_done_pulse", done, 0);
    check("add1_idle_busy", busy, 0);
    a = 8'hAA;
    b = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check("add1_hold_idle", result, 8'h61);
    check("add1_no_spurious", busy, 0);

    // 0x80 - 0x01
    run_op(1'b1, 8'h80, 8'h01, lat);
    check("sub1_latency", lat, 9);
    check_outputs("sub1", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Abort in the third RUN cycle
    sub   = 1'b0;
    a     = 8'h11;
    b     = 8'h22;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_outputs("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // Recovery: 0x10 - 0x20
    run_op(1'b1, 8'h10, 8'h20, lat);
    check("rec_latency", lat, 9);
    check_outputs("rec", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;

    // 0x7F + 0x01
    run_op(1'b0, 8'h7F, 8'h01, lat);
    check("add2_latency", lat, 9);
    check_outputs("add2", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // 0xFF + 0x01
    run_op(1'b0, 8'hFF, 8'h01, lat);
    check("add3_latency", lat, 9);
    check_outputs("add3", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // 0x05 - 0x05 with start and operands disturbed every RUN cycle
    sub   = 1'b1;
    a     = 8'h05;
    b     = 8'h05;
    start = 1'b1;
    @(posedge clk); #1;
    lat    = 1;
    pulses = 0;
    while (!done && lat < 40) begin
      a     = 8'(lat * 37 + 3);
      b     = 8'(lat * 11 + 200);
      start = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    if (done) pulses++;
    check("dist_latency", lat, 9);
    check_outputs("dist", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("dist_single_done", pulses, 1);
    check("dist_hold_idle", result, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = A+B, 1 = A-B (two's complement, B inverted, carry-in 1).
REQ-006 SHALL have port a  input  WIDTH  operand A, captured with start.
REQ-007 SHALL have port b  input  WIDTH  operand B, captured with start.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  WIDTH  sum/difference, stable from done until next accepted start.
REQ-011 SHALL have port cout  output  1  final carry-out (for sub: 1 = no borrow).
REQ-012 SHALL have ports ovf, zero, neg  output  1 each  signed overflow, result==0, result MSB.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after exactly WIDTH RUN cycles, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on accepting start, latch a, b, sub, load the carry flip-flop with sub, and clear the bit counter.
REQ-015 SHALL process one bit per RUN cycle, LSB first, using one 1-bit full-adder stage: s = a[i] ^ (b[i] ^ sub) ^ c; c <= majority(a[i], b[i]^sub, c).
REQ-016 SHALL shift each sum bit into the result register from the MSB end so result holds the full WIDTH-bit value on entry to DONE.
REQ-017 SHALL assert busy iff state is RUN and done iff state is DONE; latency from start-sampling edge to done high is WIDTH+1 cycles.
REQ-018 SHALL ignore start while in RUN or DONE; latched operands are not disturbed by changes on a, b, sub after capture.
REQ-019 SHALL update result, cout and flags only on RUN->DONE; they hold their values in IDLE until the next accepted start (they may change during RUN only if internal, not on outputs).
REQ-020 SHALL set cout to the final carry, ovf to carry-into-MSB XOR carry-out, zero to (result==0), neg to result[WIDTH-1].
REQ-021 SHALL wrap results modulo 2^WIDTH; no saturation.

Reset
REQ-022 SHALL, with rst=1 at a clock edge, enter IDLE and clear busy, done, result, cout, ovf, zero, neg, carry, counter and latched operands to 0.
REQ-023 SHALL give rst priority over start and over an operation in progress; an aborted operation produces no done pulse.

Configuration
REQ-024 SHALL compile the flag logic (ovf, zero, neg) only when macro SERIAL_ADD_SUB_FLAGS_EN is defined.
REQ-025 SHALL, without SERIAL_ADD_SUB_FLAGS_EN, keep ports ovf, zero, neg present but drive them constantly 0; result, cout and timing are unchanged.

Verification
REQ-026 SHALL cover WIDTH=8, sub=0, a=0x3C, b=0x25 -> done after 9 cycles, result=0x61, cout=0, ovf=0, zero=0, neg=0.
REQ-027 SHALL cover sub=1, a=0x80, b=0x01 -> result=0x7F, cout=1, ovf=1, neg=0 (flags macro defined).
REQ-028 SHALL cover sub=0, a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1, neg=1; and a=0xFF, b=0x01 -> result=0x00, cout=1, zero=1, ovf=0.
REQ-029 SHALL cover sub=1, a=0x05, b=0x05 with start re-asserted and a changed every RUN cycle -> result=0x00, cout=1, zero=1, single done pulse.
REQ-030 SHALL cover rst=1 in 3rd RUN cycle -> next cycle busy=0, done never asserts, all outputs 0; new start then completes normally.
REQ-031 SHALL cover build without SERIAL_ADD_SUB_FLAGS_EN, repeating REQ-027 -> result=0x7F, cout=1, ovf=zero=neg=0.
